// File: rtl/plic_ctrl_pkg.sv
// plic_ctrl_pkg: shared target state type, id/owner width helpers and default
// counter widths for the PLIC claim/complete sequencer.
package plic_ctrl_pkg;

    typedef enum logic {IDLE, WAIT_FENCE} tgt_state_e;

    localparam int DEF_TOW  = 26;
    localparam int DEF_DEFW = 5;

    function automatic int id_width(input int n_source);
        return $clog2(n_source + 1);
    endfunction

    function automatic int owner_width(input int n_target);
        return n_target > 1 ? $clog2(n_target) : 1;
    endfunction

endpackage

// File: rtl/plic_claim_timer.sv
// plic_claim_timer: one source's claim timeout counter; with PLIC_OWNER_CHECK_EN
// it also holds the owning target and an owner-valid flag.
module plic_claim_timer #(
    parameter int TOW  = 26,
    parameter int TGTW = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  logic            clear_i,
    input  logic [TOW-1:0]  reload_i,
`ifdef PLIC_OWNER_CHECK_EN
    input  logic [TGTW-1:0] owner_i,
    output logic [TGTW-1:0] owner_o,
    output logic            owner_vld_o,
`endif
    output logic            expire_o
);

    logic [TOW-1:0] cnt_q;

    // a reload or an explicit complete in the expiry cycle pre-empts the timeout
    assign expire_o = cnt_q == TOW'(1) && !load_i && !clear_i;

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) cnt_q <= '0;
        else if (load_i) cnt_q <= reload_i;
        else if (clear_i) cnt_q <= '0;
        else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;

`ifdef PLIC_OWNER_CHECK_EN
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            owner_o     <= '0;
            owner_vld_o <= 1'b0;
        end else if (load_i) begin
            owner_o     <= owner_i;
            owner_vld_o <= 1'b1;
        end else if (clear_i || expire_o) begin
            owner_vld_o <= 1'b0;
        end
`else
    localparam int unused_tgtw = TGTW;
`endif

endmodule

// File: rtl/plic_claim_ctrl.sv
// plic_claim_ctrl: per-target claim/fence sequencer plus per-source claim timers
// driving the PLIC gateway. Define PLIC_OWNER_CHECK_EN to accept completes only from the owner.
module plic_claim_ctrl
    import plic_ctrl_pkg::*;
#(
    parameter int N_SOURCE = 30,
    parameter int N_TARGET = 2,
    parameter int TOW      = DEF_TOW,
    parameter int DEFW     = DEF_DEFW,
    parameter int SRCW     = id_width(N_SOURCE),
    parameter int TGTW     = owner_width(N_TARGET)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [N_TARGET-1:0]           claim_re_i,
    input  logic [N_TARGET-1:0][SRCW-1:0] claim_id_i,
    input  logic [N_TARGET-1:0]           fence_i,
    input  logic [N_TARGET-1:0]           complete_we_i,
    input  logic [N_TARGET-1:0][SRCW-1:0] complete_id_i,
    input  logic [TOW-1:0]                cfg_timeout_i,
    input  logic [DEFW-1:0]               cfg_defer_i,
    output logic [N_SOURCE-1:0]           claim_o,
    output logic [N_SOURCE-1:0]           complete_o,
    output logic [N_SOURCE-1:0]           timeout_o,
    output logic [N_TARGET-1:0]           irq_mask_o,
    output logic [15:0]                   drop_cnt_o
);

    localparam logic [SRCW-1:0] MAX_ID = SRCW'(N_SOURCE);

    logic [N_TARGET-1:0]           commit, abandon;
    logic [N_TARGET-1:0][SRCW-1:0] commit_id;
    logic [N_SOURCE-1:0]           load, cmp, expire;
    logic [15:0]                   drops;
    logic [16:0]                   drop_sum;
`ifdef PLIC_OWNER_CHECK_EN
    logic [TGTW-1:0]     load_tgt [N_SOURCE];
    logic [TGTW-1:0]     owner    [N_SOURCE];
    logic [N_SOURCE-1:0] owner_vld;
`else
    localparam int unused_tgtw = TGTW;
`endif

    for (genvar t = 0; t < N_TARGET; t++) begin : g_tgt
        tgt_state_e      state_q, state_d;
        logic [DEFW-1:0] win_q, win_d;
        logic [SRCW-1:0] id_q, id_d;
        logic            commit_t, abandon_t;
        always_comb begin
            state_d   = state_q;
            win_d     = win_q;
            id_d      = id_q;
            commit_t  = 1'b0;
            abandon_t = 1'b0;
            if (state_q == IDLE) begin
                if (claim_re_i[t] && claim_id_i[t] != '0) begin
                    state_d = WAIT_FENCE;
                    win_d   = cfg_defer_i;
                    id_d    = claim_id_i[t];
                end
            end else if (fence_i[t]) begin
                state_d  = IDLE;
                commit_t = 1'b1;
            end else if (win_q == '0) begin
                state_d   = IDLE;
                abandon_t = 1'b1;
            end else begin
                win_d = win_q - 1'b1;
            end
        end
        always_ff @(posedge clk_i or negedge rst_ni)
            if (!rst_ni) begin
                state_q <= IDLE;
                win_q   <= '0;
                id_q    <= '0;
            end else begin
                state_q <= state_d;
                win_q   <= win_d;
                id_q    <= id_d;
            end
        assign commit[t]     = commit_t;
        assign abandon[t]    = abandon_t;
        assign commit_id[t]  = id_q;
        assign irq_mask_o[t] = state_q == WAIT_FENCE;
    end

    // lowest target index wins a contested source; every loser counts as a drop
    always_comb begin
        logic [SRCW-1:0] idx;
        idx   = '0;
        load  = '0;
        cmp   = '0;
        drops = '0;
`ifdef PLIC_OWNER_CHECK_EN
        load_tgt = '{default: '0};
`endif
        for (int i = 0; i < N_TARGET; i++) begin
            if (abandon[i]) drops = drops + 16'd1;
            idx = commit_id[i] - 1'b1;
            if (commit[i]) begin
                if (commit_id[i] > MAX_ID || load[idx]) begin
                    drops = drops + 16'd1;
                end else begin
                    load[idx] = 1'b1;
`ifdef PLIC_OWNER_CHECK_EN
                    load_tgt[idx] = TGTW'(i);
`endif
                end
            end
            idx = complete_id_i[i] - 1'b1;
            if (complete_we_i[i] && complete_id_i[i] != '0 && complete_id_i[i] <= MAX_ID) begin
`ifdef PLIC_OWNER_CHECK_EN
                if (owner_vld[idx] && owner[idx] == TGTW'(i)) cmp[idx] = 1'b1;
                else drops = drops + 16'd1;
`else
                cmp[idx] = 1'b1;
`endif
            end
        end
    end

    for (genvar s = 0; s < N_SOURCE; s++) begin : g_src
        plic_claim_timer #(.TOW(TOW), .TGTW(TGTW)) u_timer (
            .clk_i,
            .rst_ni,
            .load_i      (load[s]),
            .clear_i     (cmp[s]),
            .reload_i    (cfg_timeout_i),
`ifdef PLIC_OWNER_CHECK_EN
            .owner_i     (load_tgt[s]),
            .owner_o     (owner[s]),
            .owner_vld_o (owner_vld[s]),
`endif
            .expire_o    (expire[s])
        );
    end

    assign drop_sum = {1'b0, drop_cnt_o} + {1'b0, drops};

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            claim_o    <= '0;
            complete_o <= '0;
            timeout_o  <= '0;
            drop_cnt_o <= '0;
        end else begin
            claim_o    <= load;
            complete_o <= cmp | expire;
            timeout_o  <= expire;
            drop_cnt_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end

endmodule
